// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants for the writeback-port arbiter: requester roles and counter width.
package wb_arb_pkg;

    localparam int REQ_PIPE   = 0;
    localparam int REQ_MULDIV = 1;
    localparam int REQ_FPU    = 2;

    localparam int DEF_NREQ = 3;
    localparam int WAIT_W   = 4;

endpackage

// File: rtl/wb_port_arbiter_rr_picker.sv
// Combinational rotating-priority picker: the first requested slot at or after
// i_base (wrapping) wins.
module rr_picker #(
    parameter int  N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_base,
    output logic [N-1:0]  o_grant_oh,
    output logic          o_any
);

    function automatic int slot(input int b, input int k);
        int s;
        s = b + k;
        if (s >= N) s = s - N;
        return s;
    endfunction

    always_comb begin
        o_grant_oh = '0;
        o_any      = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!o_any && i_req[j] && (slot(int'(i_base), k) == j)) begin
                    o_grant_oh[j] = 1'b1;
                    o_any         = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback-port arbiter: fixed-priority pipe, round-robin variable-latency units,
// and per-unit starvation counters that force a grant after MAX_WAIT waited cycles.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int  NREQ     = DEF_NREQ,
    parameter int  MAX_WAIT = 4,
    localparam int IW       = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic            wb_stall_i,
    input  logic            flush_i,
    output logic            wb_en,
    output logic            wb_clear,
    output logic [NREQ-1:0] grant_oh,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_valid
);

    localparam int                NRR   = NREQ - 1;
    localparam int                PW    = (NRR > 1) ? $clog2(NRR) : 1;
    localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);

    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        return (v >= MAX_W) ? MAX_W : v + 1'b1;
    endfunction

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] idx);
        return (int'(idx) == NREQ - 1) ? IW'(1) : idx + 1'b1;
    endfunction

    logic [IW-1:0]     r_rr_ptr;
    logic [WAIT_W-1:0] r_wait_cnt [1:NREQ-1];

    logic [NREQ-1:0]   w_starve;
    logic [NREQ-1:0]   w_ovr_oh;
    logic [NREQ-1:0]   w_grant_oh;
    logic [NRR-1:0]    w_rr_oh;
    logic              w_rr_any;
    logic [PW-1:0]     w_rr_base;
    logic [IW-1:0]     w_grant_idx;
    logic              w_arb;

    always_comb begin
        w_starve = '0;
        for (int i = 1; i < NREQ; i++)
            w_starve[i] = req_valid[i] && (r_wait_cnt[i] == MAX_W);
    end

    // Isolate the lowest starving requester.
    assign w_ovr_oh  = w_starve & (~w_starve + 1'b1);
    assign w_rr_base = PW'(r_rr_ptr - 1'b1);

    rr_picker #(.N(NRR)) u_rr_picker (
        .i_req      (req_valid[NREQ-1:1]),
        .i_base     (w_rr_base),
        .o_grant_oh (w_rr_oh),
        .o_any      (w_rr_any)
    );

    assign w_arb = !rst && !flush_i && !wb_stall_i;

    always_comb begin
        w_grant_oh = '0;
        if (w_arb) begin
            if (|w_starve)
                w_grant_oh = w_ovr_oh;
            else if (req_valid[REQ_PIPE])
                w_grant_oh[REQ_PIPE] = 1'b1;
            else if (w_rr_any)
                w_grant_oh = {w_rr_oh, 1'b0};
        end
    end

    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (w_grant_oh[i]) w_grant_idx = IW'(i);
    end

    assign grant_oh    = w_grant_oh;
    assign req_ready   = w_grant_oh;
    assign grant_idx   = w_grant_idx;
    assign grant_valid = |w_grant_oh;
    assign wb_en       = rst || flush_i || !wb_stall_i;
    assign wb_clear    = rst || flush_i || (!wb_stall_i && !grant_valid);

    // Flush clears the wait history but keeps the round-robin position.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= IW'(1);
            for (int i = 1; i < NREQ; i++) r_wait_cnt[i] <= '0;
        end else if (flush_i) begin
            for (int i = 1; i < NREQ; i++) r_wait_cnt[i] <= '0;
        end else begin
            for (int i = 1; i < NREQ; i++) begin
                if (w_grant_oh[i] || !req_valid[i])
                    r_wait_cnt[i] <= '0;
                else
                    r_wait_cnt[i] <= sat_inc(r_wait_cnt[i]);
            end
            if (grant_valid && (w_grant_idx != '0))
                r_rr_ptr <= next_ptr(w_grant_idx);
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and randomized bench for wb_port_arbiter against a rule-level reference model.
module tb_wb_port_arbiter;

    localparam int N  = 3;
    localparam int MW = 4;
    localparam int IW = $clog2(N);

    logic          clk;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic          wb_stall_i;
    logic          flush_i;
    logic          wb_en;
    logic          wb_clear;
    logic [N-1:0]  grant_oh;
    logic [IW-1:0] grant_idx;
    logic          grant_valid;

    int n_vec;
    int n_err;

    int m_wait [1:N-1];
    int m_ptr;
    bit m_known;

    wb_port_arbiter #(.NREQ(N), .MAX_WAIT(MW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .wb_stall_i  (wb_stall_i),
        .flush_i     (flush_i),
        .wb_en       (wb_en),
        .wb_clear    (wb_clear),
        .grant_oh    (grant_oh),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns the winning requester index, or -1 when nobody is granted.
    function automatic int model_grant(input logic [N-1:0] v, input logic s, input logic f,
                                       input logic r);
        if (r || f || s) return -1;
        for (int i = 1; i < N; i++)
            if (m_wait[i] == MW && v[i]) return i;
        if (v[0]) return 0;
        for (int k = 0; k < N - 1; k++) begin
            int j;
            j = ((m_ptr - 1 + k) % (N - 1)) + 1;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic step(input logic r, input logic [N-1:0] v, input logic s, input logic f);
        int g;
        logic [N-1:0] exp_oh;
        logic exp_en, exp_clr;
        @(negedge clk);
        rst        = r;
        req_valid  = v;
        wb_stall_i = s;
        flush_i    = f;
        #1;
        if (m_known) begin
            chk("rr_ptr", 32'(dut.r_rr_ptr), 32'(m_ptr));
            for (int i = 1; i < N; i++)
                chk($sformatf("wait_cnt%0d", i), 32'(dut.r_wait_cnt[i]), 32'(m_wait[i]));
        end
        g      = model_grant(v, s, f, r);
        exp_oh = (g >= 0) ? N'(1 << g) : '0;
        if (r || f)      begin exp_en = 1'b1; exp_clr = 1'b1; end
        else if (s)      begin exp_en = 1'b0; exp_clr = 1'b0; end
        else if (g >= 0) begin exp_en = 1'b1; exp_clr = 1'b0; end
        else             begin exp_en = 1'b1; exp_clr = 1'b1; end
        chk("grant_oh",    32'(grant_oh),    32'(exp_oh));
        chk("req_ready",   32'(req_ready),   32'(exp_oh));
        chk("grant_valid", 32'(grant_valid), 32'(g >= 0));
        chk("wb_en",       32'(wb_en),       32'(exp_en));
        chk("wb_clear",    32'(wb_clear),    32'(exp_clr));
        if (g >= 0 || r) chk("grant_idx", 32'(grant_idx), (g >= 0) ? 32'(g) : 32'd0);
        if (r) begin
            m_ptr   = 1;
            for (int i = 1; i < N; i++) m_wait[i] = 0;
            m_known = 1'b1;
        end else if (f) begin
            for (int i = 1; i < N; i++) m_wait[i] = 0;
        end else begin
            for (int i = 1; i < N; i++)
                m_wait[i] = (g == i || !v[i]) ? 0 : ((m_wait[i] + 1 > MW) ? MW : m_wait[i] + 1);
            if (g >= 1) m_ptr = (g % (N - 1)) + 1;
        end
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        m_known    = 1'b0;
        m_ptr      = 1;
        for (int i = 1; i < N; i++) m_wait[i] = 0;
        rst        = 1'b1;
        req_valid  = '0;
        wb_stall_i = 1'b0;
        flush_i    = 1'b0;

        // Reset with everyone requesting, then requesters 1 and 2 alternate.
        step(1'b1, 3'b111, 1'b0, 1'b0);
        step(1'b1, 3'b111, 1'b0, 1'b0);
        repeat (4) step(1'b0, 3'b110, 1'b0, 1'b0);

        // Pipe plus requester 1: starvation override every fifth cycle.
        repeat (10) step(1'b0, 3'b011, 1'b0, 1'b0);

        // Stall saturates requester 2's counter; release gives 2 then 0.
        repeat (5) step(1'b0, 3'b101, 1'b1, 1'b0);
        repeat (2) step(1'b0, 3'b101, 1'b0, 1'b0);

        // Build some waiting, then flush while stalled.
        repeat (2) step(1'b0, 3'b111, 1'b1, 1'b0);
        step(1'b0, 3'b111, 1'b1, 1'b1);
        step(1'b0, 3'b111, 1'b0, 1'b0);

        // Idle bubbles.
        repeat (3) step(1'b0, 3'b000, 1'b0, 1'b0);

        // Reach rr_ptr=2 and wait_cnt[1]=3, then reset mid-stream.
        step(1'b0, 3'b010, 1'b0, 1'b0);
        repeat (3) step(1'b0, 3'b011, 1'b0, 1'b0);
        step(1'b1, 3'b011, 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b0, 1'b0);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            step(($urandom % 100) < 2, N'($urandom), ($urandom % 100) < 20,
                 ($urandom % 100) < 5);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Schedules the single writeback stage among several result producers:
  - requester 0: the in-order pipe (ALU/mem/CSR results);
  - requesters 1..NREQ-1: variable-latency units (MUL_DIV, FPU).
- Drives the WB pipeline register's en/clear and the result-mux select, and returns a ready to each producer.
- Requester 0 has fixed top priority. The others share the leftover slots round-robin. A per-requester starvation counter guarantees forward progress.

Parameters:
- NREQ, 3, number of requesters (2..8).
- MAX_WAIT, 4, number of waited cycles after which a requester overrides all priority (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester result valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero; equals grant_oh.
- wb_stall_i  in  1  downstream hold of the WB stage.
- flush_i  in  1  pipeline flush (trap/redirect).
- wb_en  out  1  WB register load enable.
- wb_clear  out  1  WB register load-zero (bubble).
- grant_oh  out  NREQ  one-hot winner.
- grant_idx  out  clog2(NREQ)  binary winner, for the data mux.
- grant_valid  out  1  a requester is accepted this cycle.

Behaviour:
- Grant logic is combinational from req_valid, stall, flush and the state; state updates on the clk rising edge. Latency from req_valid to grant is 0 cycles; a transfer completes when req_valid & req_ready.
- State:
  - rr_ptr[clog2(NREQ)], ranging 1..NREQ-1; reset value 1.
  - wait_cnt[i] for i=1..NREQ-1, 4 bits each, saturating at MAX_WAIT; reset value 0.
- While rst=1, outputs are forced: wb_en=1, wb_clear=1, grant_oh=0, grant_idx=0, grant_valid=0, req_ready=0. State is loaded to its reset values.
- Priority, evaluated each cycle, first match wins:
  1. flush_i=1 → wb_en=1, wb_clear=1, no grant; all wait_cnt cleared; rr_ptr held. Flush beats stall.
  2. wb_stall_i=1 → wb_en=0, wb_clear=0, no grant; each valid requester's wait_cnt increments (saturating).
  3. Starvation override: if any i≥1 has wait_cnt[i]==MAX_WAIT and req_valid[i], grant the lowest such i. This beats requester 0.
  4. req_valid[0] → grant 0.
  5. Round-robin over 1..NREQ-1: search from rr_ptr upward, wrapping NREQ-1 → 1; grant the first valid requester.
  6. No valid requester → wb_en=1, wb_clear=1 (bubble), no grant.
- On any grant: wb_en=1, wb_clear=0, grant_valid=1.
- rr_ptr update: on a grant to i≥1 (whether via override or RR), rr_ptr ← i+1, wrapping to 1 past NREQ-1. A grant to requester 0 leaves rr_ptr unchanged.
- wait_cnt[i] update (i≥1), non-flush cycles:
  - granted, or req_valid[i]=0 → 0;
  - otherwise → min(wait_cnt[i]+1, MAX_WAIT).
- Requester 0 has no counter.
- req_valid dropping without a grant is legal: the counter clears and no state error results.
- NREQ=2: the RR set holds only requester 1 and rr_ptr is constant 1.

Decomposition:
- Package wb_arb_pkg:
  - requester index constants REQ_PIPE=0, REQ_MULDIV=1, REQ_FPU=2;
  - default NREQ;
  - WAIT_W=4.
- Sub-module rr_picker: purely combinational rotating-priority one-hot picker (inputs: request vector, pointer; outputs: one-hot grant, any). It is instantiated once for the RR tier.
- Counters, rr_ptr, override selection and en/clear generation stay in the top module.

Test Plan (NREQ=3, MAX_WAIT=4 unless stated):
- Reset with all req_valid=1 for 2 cycles → wb_en=1, wb_clear=1, req_ready=000. After release, with only valid={1,2} → grants 1,2,1,2 (rr_ptr wraps 2→1).
- req_valid={0,1} held for 10 cycles → grant sequence 0,0,0,0,1,0,0,0,0,1; wait_cnt[1] reads 1,2,3,4,0 across each period.
- valid={0,2}, wb_stall_i=1 for 5 cycles → wb_en=0, req_ready=000, wait_cnt[2] saturates at 4. On stall release, the first grant is 2 (override), then 0.
- flush_i=1 together with wb_stall_i=1 and all valid → wb_en=1, wb_clear=1, no ready, all wait_cnt=0, rr_ptr unchanged.
- No valid and no stall for 3 cycles → wb_en=1, wb_clear=1, grant_valid=0 every cycle.
- rst asserted mid-stream while wait_cnt[1]=3 and rr_ptr=2 → the next cycle shows rr_ptr=1, wait_cnt=0, and forced bubble outputs.
